// File: rtl/gate_tt_pkg.sv
// gate_tt_pkg: shared state encoding and default truth tables for the gate checker.
package gate_tt_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
endpackage

// File: rtl/gate_tt_settle_timer.sv
// gate_tt_settle_timer: up-counter cleared by load, flags terminal count SETTLE-1.
module gate_tt_settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic tc
);
  localparam int W = SETTLE > 1 ? $clog2(SETTLE) : 1;
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= load ? '0 : r_cnt + W'(1);
  assign tc = r_cnt == W'(SETTLE - 1);
endmodule

// File: rtl/gate_tt_checker.sv
// gate_tt_checker: drives every input vector into a gate under test and checks
// the sampled output against the expected truth table EXP_TT.
module gate_tt_checker
  import gate_tt_pkg::*;
#(
  parameter int                      N_IN   = 2,
  parameter logic [(1<<N_IN)-1:0]    EXP_TT = TT_NAND,
  parameter int                      SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] gate_in,
  input  logic            gate_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic            fail_valid,
  output logic [N_IN-1:0] first_fail_vec
);
  state_t          r_state, w_next;
  logic [N_IN-1:0] r_gate_in, r_first_fail;
  logic [N_IN:0]   r_err_cnt;
  logic            r_fail_valid, r_pass;
  logic            w_tc, w_last, w_mis, w_accept;
  gate_tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (r_state != ST_SETTLE),
    .tc    (w_tc)
  );
  assign w_last   = r_gate_in == '1;
  assign w_mis    = gate_out != EXP_TT[r_gate_in];
  assign w_accept = r_state == ST_IDLE && start;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   w_next = start ? ST_SETTLE : ST_IDLE;
      ST_SETTLE: w_next = w_tc ? ST_SAMPLE : ST_SETTLE;
      ST_SAMPLE: w_next = w_last ? ST_DONE : ST_SETTLE;
      default:   w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_gate_in    <= '0;
      r_err_cnt    <= '0;
      r_fail_valid <= 1'b0;
      r_first_fail <= '0;
      r_pass       <= 1'b0;
    end else if (w_accept) begin
      r_gate_in    <= '0;
      r_err_cnt    <= '0;
      r_fail_valid <= 1'b0;
      r_first_fail <= '0;
      r_pass       <= 1'b0;
    end else if (r_state == ST_SAMPLE) begin
      if (w_mis) r_err_cnt <= r_err_cnt + (N_IN+1)'(1);
      if (w_mis && !r_fail_valid) begin
        r_first_fail <= r_gate_in;
        r_fail_valid <= 1'b1;
      end
      if (!w_last) r_gate_in <= r_gate_in + N_IN'(1);
    end else if (r_state == ST_DONE) begin
      r_pass <= r_err_cnt == '0;
    end
  assign gate_in        = r_gate_in;
  assign busy           = r_state == ST_SETTLE || r_state == ST_SAMPLE;
  assign done           = r_state == ST_DONE;
  assign pass           = r_pass;
  assign err_cnt        = r_err_cnt;
  assign fail_valid     = r_fail_valid;
  assign first_fail_vec = r_first_fail;
endmodule

// File: tb/tb_gate_tt_checker.sv
// tb_gate_tt_checker: table, hand-written and random runs on a 2-input and a
// 3-input checker, each gate modelled as an arbitrary truth table.
module tb_gate_tt_checker;
  logic       clk = 1'b0, rst_n = 1'b0, start2 = 1'b0, start3 = 1'b0;
  logic [3:0] tt2 = 4'b0111;
  logic [7:0] tt3 = 8'h7F;
  logic [1:0] gi2, ffv2;
  logic [2:0] gi3, ffv3, err2;
  logic [3:0] err3;
  logic       busy2, done2, pass2, fv2, busy3, done3, pass3, fv3;
  int vectors = 0, miscompares = 0;
  localparam logic [3:0] NAND2 = 4'b0111;
  localparam logic [7:0] NAND3 = 8'b0111_1111;

  always #5 clk = ~clk;

  gate_tt_checker u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .gate_in(gi2), .gate_out(tt2[gi2]),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
    .fail_valid(fv2), .first_fail_vec(ffv2)
  );
  gate_tt_checker #(.N_IN(3), .EXP_TT(NAND3), .SETTLE(1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .gate_in(gi3), .gate_out(tt3[gi3]),
    .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3),
    .fail_valid(fv3), .first_fail_vec(ffv3)
  );

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: every vector whose observed output differs from the expected table is an error.
  task automatic model(input logic [7:0] got, input logic [7:0] exp, input int nv,
                       output int err, output int ffv);
    err = 0;
    ffv = 0;
    for (int i = nv - 1; i >= 0; i--)
      if (got[i] != exp[i]) begin
        err++;
        ffv = i;
      end
  endtask

  task automatic run(input int sel, input logic [7:0] tt, input int exp_err,
                     input int exp_ffv, input string nm, input bit rep);
    int n, s, nv, len, bc, dc, dk, bad, gi, e, fv, ff, p;
    n = sel ? 3 : 2;
    s = sel ? 1 : 2;
    nv = 1 << n;
    len = nv * (s + 1);
    bc = 0; dc = 0; dk = 0; bad = 0; e = 0; fv = 0; ff = 0; p = 0;
    if (sel) tt3 = tt; else tt2 = tt[3:0];
    @(negedge clk);
    if (sel) start3 = 1'b1; else start2 = 1'b1;
    for (int k = 1; k <= len + 4; k++) begin
      @(negedge clk);
      if (sel ? busy3 : busy2) bc++;
      if (sel ? done3 : done2) begin dc++; dk = k; end
      gi = sel ? int'(gi3) : int'(gi2);
      if (gi != (k <= len ? (k - 1) / (s + 1) : nv - 1)) bad++;
      if (k == len + 2) begin
        e  = sel ? int'(err3) : int'(err2);
        fv = sel ? int'(fv3) : int'(fv2);
        ff = sel ? int'(ffv3) : int'(ffv2);
        p  = sel ? int'(pass3) : int'(pass2);
      end
      start2 = !sel && rep && (k == 3 || k == 7 || k == len + 1);
      start3 = sel && rep && (k == 3 || k == 7 || k == len + 1);
    end
    chk({nm, " busy_cycles"}, bc, len);
    chk({nm, " done_count"}, dc, 1);
    chk({nm, " done_cycle"}, dk, len + 1);
    chk({nm, " gate_in_seq_errs"}, bad, 0);
    chk({nm, " err_cnt"}, e, exp_err);
    chk({nm, " fail_valid"}, fv, exp_err != 0);
    if (exp_err != 0) chk({nm, " first_fail_vec"}, ff, exp_ffv);
    chk({nm, " pass"}, p, exp_err == 0);
  endtask

  typedef struct {
    logic [3:0] tt;
    int         err;
    int         ffv;
    string      nm;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int   e, f, dc;
    logic [7:0] r;
    tbl[0] = '{4'b0111, 0, 0, "nand"};
    tbl[1] = '{4'b1000, 4, 0, "and_on_nand"};
    tbl[2] = '{4'b1111, 1, 3, "stuck1"};
    tbl[3] = '{4'b0000, 3, 0, "stuck0"};
    tbl[4] = '{4'b1110, 2, 0, "or_on_nand"};
    tbl[5] = '{4'b0110, 1, 0, "xor_on_nand"};

    repeat (3) @(negedge clk);
    chk("rst outputs2", int'({gi2, busy2, done2, pass2, err2, fv2, ffv2}), 0);
    chk("rst outputs3", int'({gi3, busy3, done3, pass3, err3, fv3, ffv3}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle no start busy", int'(busy2), 0);

    for (int i = 0; i < 6; i++) run(0, {4'b0, tbl[i].tt}, tbl[i].err, tbl[i].ffv, tbl[i].nm, 1'b0);

    run(0, {4'b0, NAND2}, 0, 0, "repulse", 1'b1);
    run(0, 8'h08, 4, 0, "restart_after_idle", 1'b0);

    // Abort mid-run with a nonzero error count already accumulated.
    tt2 = 4'b1000;
    @(negedge clk);
    start2 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start2 = 1'b0;
    end
    chk("pre_rst err_cnt", int'(err2), 1);
    #2 rst_n = 1'b0;
    #1 chk("async rst outputs", int'({gi2, busy2, done2, pass2, err2, fv2, ffv2}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dc = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done2 || busy2) dc++;
    end
    chk("no done after rst", dc, 0);
    run(0, {4'b0, NAND2}, 0, 0, "post_rst", 1'b0);

    run(1, NAND3, 0, 0, "nand3", 1'b0);
    run(1, 8'hFF, 1, 7, "nand3_stuck1", 1'b1);

    for (int i = 0; i < 12; i++) begin
      r = 8'($urandom);
      model(r, {4'b0, NAND2}, 4, e, f);
      run(0, r, e, f, "rand2", i[0]);
      r = 8'($urandom);
      model(r, NAND3, 8, e, f);
      run(1, r, e, f, "rand3", i[1]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
